mult_acc_pipe: RTL and testbench

- Parametrised, pipelined successor to the plain combinational multiplier.
- Multiplies A_WIDTH x B_WIDTH operands in signed or unsigned mode, per beat.
- Optionally accumulates the product into an ACC_WIDTH accumulator.
- Valid/ready streaming on both sides; sits between operand sources and DSP-mapped datapaths in the QLF test designs.

---
 rtl/mult_acc_pipe.sv | 162 ++++++++++++++++
 tb/tb_mult_acc_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with valid/ready streaming on both sides.
// PIPE_STAGES cycles from acceptance to out; every stage freezes while the output is stalled.
module mult_acc_pipe #(
  parameter int A_WIDTH     = 16,
  parameter int B_WIDTH     = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 is_signed,
  input  logic                 acc_en,
  input  logic                 acc_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 overflow
);

  localparam int PW = A_WIDTH + B_WIDTH;

  typedef struct packed {
    logic               vld;
    logic               sgn;
    logic               en;
    logic               clr;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
  } op_t;

  typedef struct packed {
    logic                 vld;
    logic                 sgn;
    logic                 en;
    logic                 clr;
    logic [ACC_WIDTH-1:0] p;
  } prod_t;

  logic                 adv;
  op_t                  op_in;
  op_t                  mul_op;
  prod_t                prod_c;
  prod_t                fin;
  logic [PW-1:0]        mul_a_x;
  logic [PW-1:0]        mul_b_x;
  logic [PW-1:0]        mul_p;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic                 overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign op_in     = {in_valid, is_signed, acc_en, acc_clear, a, b};

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign mul_op = op_in;
    end else begin : g_opreg
      op_t op_q, op_d;

      always_comb begin
        op_d = op_q;
        if (adv) op_d = op_in;
      end

      always_ff @(posedge clk) begin
        if (rst) op_q <= '0;
        else     op_q <= op_d;
      end

      assign mul_op = op_q;
    end
  endgenerate

  // Low PW bits of the extended-operand product are exact in both modes; only the
  // extension above PW depends on signedness.
  always_comb begin
    mul_a_x  = {{B_WIDTH{mul_op.sgn & mul_op.a[A_WIDTH-1]}}, mul_op.a};
    mul_b_x  = {{A_WIDTH{mul_op.sgn & mul_op.b[B_WIDTH-1]}}, mul_op.b};
    mul_p    = mul_a_x * mul_b_x;
    prod_c.vld = mul_op.vld;
    prod_c.sgn = mul_op.sgn;
    prod_c.en  = mul_op.en;
    prod_c.clr = mul_op.clr;
    prod_c.p   = {ACC_WIDTH{mul_op.sgn & mul_p[PW-1]}};
    prod_c.p[PW-1:0] = mul_p;
  end

  generate
    if (PIPE_STAGES > 2) begin : g_mid
      localparam int MIDN = PIPE_STAGES - 2;
      prod_t mid_q [MIDN];
      prod_t mid_d [MIDN];

      always_comb begin
        for (int i = 0; i < MIDN; i++) mid_d[i] = mid_q[i];
        if (adv) begin
          mid_d[0] = prod_c;
          for (int i = 1; i < MIDN; i++) mid_d[i] = mid_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MIDN; i++) mid_q[i] <= '0;
        end else begin
          mid_q <= mid_d;
        end
      end

      assign fin = mid_q[MIDN-1];
    end else begin : g_nomid
      assign fin = prod_c;
    end
  endgenerate

  always_comb begin
    base        = (fin.clr || !fin.en) ? '0 : acc_q;
    sum         = {1'b0, base} + {1'b0, fin.p};
    out_valid_d = out_valid_q;
    out_d       = out_q;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = fin.vld;
      if (fin.vld) begin
        out_d      = sum[ACC_WIDTH-1:0];
        acc_d      = sum[ACC_WIDTH-1:0];
        // Signed wrap: like-signed addends producing a result of the other sign.
        overflow_d = fin.sgn ? ((base[ACC_WIDTH-1] == fin.p[ACC_WIDTH-1]) &&
                                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                             : sum[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed bench: default 40-bit/2-stage instance plus a 32-bit/3-stage instance for wrap cases.
module tb_mult_acc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, is_signed, acc_en, acc_clear, out_valid, out_ready, overflow;
  logic [15:0] a, b;
  logic [39:0] out;

  logic        w_in_valid, w_in_ready, w_is_signed, w_acc_en, w_acc_clear;
  logic        w_out_valid, w_out_ready, w_overflow;
  logic [15:0] w_a, w_b;
  logic [31:0] w_out;

  mult_acc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .acc_en(acc_en), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .overflow(overflow)
  );

  mult_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32), .PIPE_STAGES(3)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .is_signed(w_is_signed), .acc_en(w_acc_en), .acc_clear(w_acc_clear),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out(w_out), .overflow(w_overflow)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        en;
    logic        clr;
    logic [39:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs   [11];
  vec_t w_vecs [7];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends one isolated beat and waits (bounded) for its result; lat counts edges from acceptance.
  task automatic send_beat(input bit sel, input logic [15:0] ta, input logic [15:0] tb,
                           input logic ts, input logic te, input logic tc,
                           output logic [39:0] o, output logic ov, output int lat);
    @(negedge clk);
    if (!sel) begin
      in_valid = 1'b1; a = ta; b = tb; is_signed = ts; acc_en = te; acc_clear = tc;
    end else begin
      w_in_valid = 1'b1; w_a = ta; w_b = tb; w_is_signed = ts; w_acc_en = te; w_acc_clear = tc;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    lat = 1;
    #1;
    while (!(sel ? w_out_valid : out_valid) && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    o  = sel ? {8'h00, w_out} : out;
    ov = sel ? w_overflow : overflow;
  endtask

  logic [39:0] o;
  logic        ov;
  int          lat;
  logic [39:0] acc_exp [3];
  logic [3:0]  pat;
  int          sent, got;
  logic        stalled;
  logic [39:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 40'h00FFFE0001, 1'b0};
    vecs[1]  = '{16'hFFFE, 16'h0003, 1'b1, 1'b0, 1'b0, 40'hFFFFFFFFFA, 1'b0};
    vecs[2]  = '{16'h0003, 16'h0004, 1'b0, 1'b1, 1'b1, 40'h000000000C, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0006, 1'b0, 1'b1, 1'b0, 40'h000000002A, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0002, 1'b1, 1'b1, 1'b0, 40'h0000000028, 1'b0};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 40'h0040000000, 1'b0};
    vecs[6]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1, 40'hFFC0008000, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 40'h00BFFE8001, 1'b1};
    vecs[8]  = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 40'h00BFFE8002, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0005, 1'b0, 1'b1, 1'b0, 40'h00BFFE8002, 1'b0};
    vecs[10] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 40'h007FFF0002, 1'b0};

    w_vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 40'hFFFE0001, 1'b0};
    w_vecs[1] = '{16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0, 40'hFFFFFFFF, 1'b0};
    w_vecs[2] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 40'h00000000, 1'b1};
    w_vecs[3] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 40'h40000000, 1'b0};
    w_vecs[4] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 40'h7FFF0001, 1'b0};
    w_vecs[5] = '{16'h0002, 16'h7FFF, 1'b1, 1'b1, 1'b0, 40'h7FFFFFFF, 1'b0};
    w_vecs[6] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 40'h80000000, 1'b1};

    acc_exp[0] = 40'd12;
    acc_exp[1] = 40'd42;
    acc_exp[2] = 40'd40;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; acc_en = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_is_signed = 1'b0; w_acc_en = 1'b0; w_acc_clear = 1'b0;
    w_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 40'h0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_w_out_valid", w_out_valid, 1'b0);
    check("rst_w_out", w_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_w_in_ready", w_in_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      send_beat(1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].en, vecs[i].clr, o, ov, lat);
      check($sformatf("vec%0d_out", i), o, vecs[i].exp_out);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
      check($sformatf("vec%0d_lat", i), lat, 2);
    end

    // Back-to-back accumulate run: results on three consecutive cycles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = (i < 3);
      acc_en    = 1'b1;
      acc_clear = (i == 0);
      is_signed = (i == 2);
      a = (i == 0) ? 16'd3 : (i == 1) ? 16'd5 : 16'hFFFF;
      b = (i == 0) ? 16'd4 : (i == 1) ? 16'd6 : 16'd2;
      #1;
      check($sformatf("run_vld%0d", i), out_valid, (i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) check($sformatf("run_out%0d", i), out, acc_exp[i-2]);
    end

    for (int i = 0; i < 7; i++) begin
      send_beat(1'b1, w_vecs[i].a, w_vecs[i].b, w_vecs[i].sgn, w_vecs[i].en, w_vecs[i].clr, o, ov, lat);
      check($sformatf("wvec%0d_out", i), o, w_vecs[i].exp_out);
      check($sformatf("wvec%0d_ovf", i), ov, w_vecs[i].exp_ovf);
      check($sformatf("wvec%0d_lat", i), lat, 3);
    end

    // Backpressure: out_ready cycles 1,0,0,1 while 8 accumulating beats stream in.
    pat = 4'b1001;
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      a = 16'(sent + 1); b = 16'd3; is_signed = 1'b0; acc_en = 1'b1; acc_clear = (sent == 0);
      #1;
      if (stalled) begin
        check("bp_hold_vld", out_valid, 1'b1);
        check("bp_hold_out", out, held);
      end
      check("bp_in_ready", in_ready, (!out_valid || out_ready));
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got++;
        check($sformatf("bp_out%0d", got), out, 40'(3 * got * (got + 1) / 2));
      end
      stalled = out_valid && !out_ready;
      held    = out;
    end
    check("bp_count", got, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("bp_drained", out_valid, 1'b0);

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 16'd7; b = 16'd7; is_signed = 1'b0; acc_en = 1'b1; acc_clear = 1'b0;
    @(negedge clk);
    a = 16'd9; b = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out", out, 40'h0);
    check("midrst_overflow", overflow, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("midrst_quiet%0d", i), out_valid, 1'b0);
      check($sformatf("midrst_rdy%0d", i), in_ready, 1'b1);
    end
    send_beat(1'b0, 16'd2, 16'd3, 1'b0, 1'b1, 1'b0, o, ov, lat);
    check("midrst_next_out", o, 40'd6);
    check("midrst_next_ovf", ov, 1'b0);
    check("midrst_next_lat", lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
